// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iterations.
module div_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  input  logic [1:0]  i_div_op,
  output logic        o_valid,
  output logic [31:0] o_div_data
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic        sign_a_q, sign_b_q;
  logic [31:0] rem_q, quo_q, divisor_q;
  logic        spec_q;
  logic [31:0] spec_res_q;
  logic        valid_q;
  logic [31:0] data_q;

  logic        is_signed, div_zero, overflow, special;
  logic [31:0] a_mag, b_mag, spec_res_d;
  logic [32:0] rem_sh, trial;
  logic [31:0] rem_d, quo_d;
  logic [31:0] quo_fin, rem_fin, result_d;

  // Accept-time decode: magnitudes and RISC-V mandated special results.
  always_comb begin
    is_signed  = ~i_div_op[0];
    a_mag      = (is_signed && i_operand_a[31]) ? (~i_operand_a + 32'd1) : i_operand_a;
    b_mag      = (is_signed && i_operand_b[31]) ? (~i_operand_b + 32'd1) : i_operand_b;
    div_zero   = (i_operand_b == 32'd0);
    overflow   = is_signed && (i_operand_a == 32'h8000_0000) && (i_operand_b == 32'hFFFF_FFFF);
    special    = div_zero || overflow;
    spec_res_d = 32'd0;
    if (div_zero) begin
      spec_res_d = i_div_op[1] ? i_operand_a : 32'hFFFF_FFFF;
    end else if (overflow) begin
      spec_res_d = i_div_op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring step: shift {rem, quo} left, subtract divisor if it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    trial  = rem_sh - {1'b0, divisor_q};
    if (!trial[32]) begin
      rem_d = trial[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end else begin
      rem_d = rem_sh[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end
  end

  always_comb begin
    quo_fin  = (sign_a_q ^ sign_b_q) ? (~quo_q + 32'd1) : quo_q;
    rem_fin  = sign_a_q ? (~rem_q + 32'd1) : rem_q;
    result_d = spec_q ? spec_res_q : (op_q[1] ? rem_fin : quo_fin);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      op_q       <= 2'd0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      divisor_q  <= 32'd0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'd0;
      valid_q    <= 1'b0;
      data_q     <= 32'd0;
    end else if (i_flush) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            op_q       <= i_div_op;
            sign_a_q   <= is_signed & i_operand_a[31];
            sign_b_q   <= is_signed & i_operand_b[31];
            rem_q      <= 32'd0;
            quo_q      <= a_mag;
            divisor_q  <= b_mag;
            spec_q     <= special;
            spec_res_q <= spec_res_d;
            cnt_q      <= 5'd0;
`ifdef DIV_FAST_SPECIAL_EN
            state_q    <= special ? StDone : StBusy;
`else
            state_q    <= StBusy;
`endif
          end
        end
        StBusy: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          data_q  <= result_d;
          valid_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready    = (state_q == StIdle);
  assign o_valid    = valid_q;
  assign o_div_data = data_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; latency expectations follow DIV_FAST_SPECIAL_EN.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, ready, out_valid;
  logic [31:0] op_a, op_b, data;
  logic [1:0]  div_op;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

  div_unit dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_flush    (flush),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_operand_a(op_a),
    .i_operand_b(op_b),
    .i_div_op   (div_op),
    .o_valid    (out_valid),
    .o_div_data (data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge where o_valid is seen.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp, input bit fast);
    int lat;
    int exp_lat;
    bit seen;
`ifdef DIV_FAST_SPECIAL_EN
    exp_lat = fast ? 1 : 33;
`else
    exp_lat = 33;
`endif
    check_val({tag, "_ready_in"}, {31'd0, ready}, 32'd1);
    op_a = a; op_b = b; div_op = op; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; div_op = ~op;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = out_valid;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_data"}, data, exp);
    check_val({tag, "_ready_out"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0;
    op_a = 32'd0; op_b = 32'd0; div_op = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("rst_ready", {31'd0, ready}, 32'd1);
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_data", data, 32'd0);

    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, OpDiv, 32'hFFFF_FFFD, 1'b0);
    @(posedge clk); #1;
    check_val("pulse_single", {31'd0, out_valid}, 32'd0);
    run_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, OpRem, 32'hFFFF_FFFF, 1'b0);

    // Back-to-back: second request issued in the o_valid cycle of the first.
    run_op("divu_ff_3", 32'hFFFF_FFFF, 32'd3, OpDivu, 32'h5555_5555, 1'b0);
    run_op("remu_100_7", 32'd100, 32'd7, OpRemu, 32'd2, 1'b0);

    run_op("div_by0", 32'h1234_5678, 32'd0, OpDiv, 32'hFFFF_FFFF, 1'b1);
    run_op("rem_by0", 32'h1234_5678, 32'd0, OpRem, 32'h1234_5678, 1'b1);
    run_op("divu_by0", 32'h8000_0001, 32'd0, OpDivu, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, OpDiv, 32'h8000_0000, 1'b1);
    run_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, OpRem, 32'd0, 1'b1);
    run_op("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, OpDivu, 32'd0, 1'b0);
    run_op("remu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, OpRemu, 32'h8000_0000, 1'b0);
    run_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, OpRem, 32'd1, 1'b0);
    run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, OpDiv, 32'hFFFF_FFFD, 1'b0);

    // Flush at T+10: no result, old data held.
    op_a = 32'd1000; op_b = 32'd3; div_op = OpDivu; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_val("flush_valid", {31'd0, out_valid}, 32'd0);
    check_val("flush_ready", {31'd0, ready}, 32'd1);
    check_val("flush_data", data, 32'hFFFF_FFFD);
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check_val("flush_no_pulse", pulses, 0);
    run_op("divu_10_3", 32'd10, 32'd3, OpDivu, 32'd3, 1'b0);

    // Flush arriving together with a request wins.
    op_a = 32'd9; op_b = 32'd3; div_op = OpDivu; valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check_val("flush_req_no_pulse", pulses, 0);

    // Reset at T+20 mid-operation.
    op_a = 32'd50; op_b = 32'd5; div_op = OpDivu; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("mrst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mrst_data", data, 32'd0);
    check_val("mrst_ready", {31'd0, ready}, 32'd1);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check_val("mrst_no_pulse", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
